// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings
// and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_adder.sv
// One-bit full-adder cell (module adder) driven one bit pair per clock by
// serial_adder_ctrl.
module adder (
  output logic suma,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign suma = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: loads two WIDTH-bit operands, ripples them LSB first
// through a single full-adder cell and pulses done with the registered sum.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   s_sh_q;
  logic [WIDTH-1:0]   s_sh_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;

  adder fa0 (
    .suma (fa_sum),
    .cout (fa_cout),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q)
  );

  // New sum bit enters at the MSB; written as a shift so WIDTH=1 stays legal.
  assign s_sh_d   = (s_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            carry_q <= cin_in;
            cnt_q   <= '0;
            s_sh_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          s_sh_q  <= s_sh_d;
          carry_q <= fa_cout;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= s_sh_d;
            cout_q  <= fa_cout;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus random
// operations compared against plain a+b+cin arithmetic.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  always #100 clk = ~clk;

  // Drives one start at the current negedge, then follows the operation to its
  // done cycle. lat counts negedges after the sampling edge (-1 on timeout);
  // early_done flags a done seen before busy dropped; stable flags sum_out held.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat, output int busy_cnt, output bit stable,
                       output bit early_done);
    logic [W-1:0] prev_s;
    logic         prev_c;
    prev_s = sum_out;
    prev_c = cout_out;
    start = 1'b1; a_in = a; b_in = b; cin_in = c;
    @(negedge clk);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
    lat = -1; busy_cnt = 0; stable = 1'b1; early_done = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) begin
        busy_cnt++;
        if (sum_out !== prev_s || cout_out !== prev_c) stable = 1'b0;
      end
      @(negedge clk);
    end
    if (lat > 0 && busy) early_done = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, sum_out, cout_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, required all 0",
               busy, done, sum_out, cout_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic c);
    int lat, bc;
    bit st, ed;
    logic [W:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    do_op(a, b, c, lat, bc, st, ed);
    n_checks++;
    if (lat != W + 1) begin
      n_fail++; $display("FAIL %s latency: got %0d, required %0d", name, lat, W + 1);
    end
    n_checks++;
    if (bc != W) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d, required %0d", name, bc, W);
    end
    n_checks++;
    if ({cout_out, sum_out} !== exp) begin
      n_fail++;
      $display("FAIL %s result: got cout=%b sum=%h, required cout=%b sum=%h",
               name, cout_out, sum_out, exp[W], exp[W-1:0]);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL %s done_width: done still %b after one cycle", name, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit st, ed;
    do_op(8'hFF, 8'hFF, 1'b1, lat, bc, st, ed);
    n_checks++;
    if ({cout_out, sum_out} !== 9'h1FF || lat != W + 1) begin
      n_fail++;
      $display("FAIL b2b_first: got cout=%b sum=%h lat=%0d, required cout=1 sum=ff lat=%0d",
               cout_out, sum_out, lat, W + 1);
    end
    // Restart straight from the done cycle.
    do_op(8'h01, 8'h01, 1'b0, lat, bc, st, ed);
    n_checks++;
    if (lat != W + 1) begin
      n_fail++; $display("FAIL b2b_latency: got %0d, required %0d", lat, W + 1);
    end
    n_checks++;
    if ({cout_out, sum_out} !== 9'h002) begin
      n_fail++;
      $display("FAIL b2b_second: got cout=%b sum=%h, required cout=0 sum=02", cout_out, sum_out);
    end
    n_checks++;
    if (!st) begin
      n_fail++; $display("FAIL b2b_hold: sum_out changed while busy, required held");
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat;
    start = 1'b1; a_in = 8'h10; b_in = 8'h20; cin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin
        start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (lat != W + 1) begin
      n_fail++; $display("FAIL ignore_latency: got %0d, required %0d", lat, W + 1);
    end
    n_checks++;
    if ({cout_out, sum_out} !== 9'h030) begin
      n_fail++;
      $display("FAIL ignore_result: got cout=%b sum=%h, required cout=0 sum=30", cout_out, sum_out);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_no_restart: busy=%b after done, required 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    start = 1'b1; a_in = 8'h80; b_in = 8'h80; cin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, sum_out, cout_out} !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b done=%b sum=%h cout=%b, required all 0",
               busy, done, sum_out, cout_out);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midreset_abandon: %0d cycles with busy/done, required 0", seen);
    end
  endtask

  task automatic test_random(input int n_ops);
    int lat, bc, gap;
    bit st, ed;
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] exp;
    for (int i = 0; i < n_ops; i++) begin
      if (!done || $urandom_range(1) == 0) begin
        gap = done ? $urandom_range(3) + 1 : $urandom_range(3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          n_checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_gap op%0d: done=%b busy=%b, required 0/0", i, done, busy);
          end
        end
      end
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      case ($urandom_range(7))
        0: a = '1;
        1: begin a = '1; b = '1; end
        default: ;
      endcase
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      do_op(a, b, c, lat, bc, st, ed);
      n_checks++;
      if (lat != W + 1 || bc != W || ed) begin
        n_fail++;
        $display("FAIL rand_timing op%0d: lat=%0d busy=%0d early=%b, required lat=%0d busy=%0d",
                 i, lat, bc, ed, W + 1, W);
      end
      n_checks++;
      if ({cout_out, sum_out} !== exp) begin
        n_fail++;
        $display("FAIL rand_result op%0d %h+%h+%b: got %b_%h, required %b_%h",
                 i, a, b, c, cout_out, sum_out, exp[W], exp[W-1:0]);
      end
      n_checks++;
      if (!st) begin
        n_fail++; $display("FAIL rand_hold op%0d: sum_out changed while busy", i);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL rand_done_width: done=%b after final done cycle", done);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
    test_directed("ripple_ff_01", 8'hFF, 8'h01, 1'b0);
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    test_random(500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
